// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, ALU opcodes and the
// src1 operand-select encodings.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1001,
    ALU_XOR  = 4'b1100,
    ALU_SRL  = 4'b1101,
    ALU_SLL  = 4'b1110,
    ALU_SRA  = 4'b1111
  } alu_op_e;

  // 2'b11 is reserved and behaves like SRC1_ZERO.
  typedef enum logic [1:0] {
    SRC1_RS1  = 2'b00,
    SRC1_PC   = 2'b01,
    SRC1_ZERO = 2'b10
  } src1_sel_e;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decoded-instruction bundle handed from the ID stage to the execute operand stage.
interface ex_operand_stage_if;
  import riscv_pkg::*;

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [3:0]      id_alu_ctrl;
  logic [1:0]      id_src1_sel;
  logic            id_src2_imm;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_branch;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl, id_src1_sel,
           id_src2_imm, id_rd, id_reg_write, id_mem_read, id_mem_write, id_branch
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_ctrl, id_src1_sel,
           id_src2_imm, id_rd, id_reg_write, id_mem_read, id_mem_write, id_branch
  );

endinterface

// File: rtl/fwd_sel.sv
// Two-source priority forwarding mux; source a beats source b, and register x0
// is never forwarded.
module fwd_sel
  import riscv_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] base,
  input  logic            a_we,
  input  logic [RA_W-1:0] a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_we,
  input  logic [RA_W-1:0] b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic [XLEN-1:0] data
);

  always_comb begin
    data = base;
    if (b_we && (b_rd != '0) && (b_rd == rs)) data = b_data;
    if (a_we && (a_rd != '0) && (a_rd == rs)) data = a_data;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with WB capture bypass, EX/MEM + MEM/WB operand
// forwarding and load-use hazard detection for the RV32I execute stage.
module ex_operand_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  ex_operand_stage_if.slave id,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_alu_out,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_wdata,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            load_use_stall
);

  logic            valid_p1, reg_write_p1, mem_read_p1, mem_write_p1, branch_p1;
  logic [XLEN-1:0] pc_p1, imm_p1, rs1_data_p1, rs2_data_p1;
  logic [RA_W-1:0] rs1_p1, rs2_p1, rd_p1;
  logic [3:0]      alu_ctrl_p1;
  logic [1:0]      src1_sel_p1;
  logic            src2_imm_p1;

  logic [XLEN-1:0] cap1, cap2, fwd1, fwd2;
  logic            bubble, ctrl_ok;

  // Capture side: a write retiring in WB this cycle is not yet visible in the regfile read.
  fwd_sel u_cap1 (
    .rs(id.id_rs1), .base(id.id_rs1_data),
    .a_we(1'b0), .a_rd('0), .a_data('0),
    .b_we(memwb_reg_write), .b_rd(memwb_rd), .b_data(memwb_wdata),
    .data(cap1)
  );

  fwd_sel u_cap2 (
    .rs(id.id_rs2), .base(id.id_rs2_data),
    .a_we(1'b0), .a_rd('0), .a_data('0),
    .b_we(memwb_reg_write), .b_rd(memwb_rd), .b_data(memwb_wdata),
    .data(cap2)
  );

  assign load_use_stall = valid_p1 && mem_read_p1 && (rd_p1 != '0) && id.id_valid &&
                          ((id.id_use_rs1 && (id.id_rs1 == rd_p1)) ||
                           (id.id_use_rs2 && (id.id_rs2 == rd_p1)));

  assign bubble  = flush || load_use_stall;
  assign ctrl_ok = id.id_valid && !bubble;

  // ---- ID -> EX boundary (p1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_p1     <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      branch_p1    <= 1'b0;
      pc_p1        <= '0;
      imm_p1       <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      alu_ctrl_p1  <= ALU_AND;
      src1_sel_p1  <= SRC1_RS1;
      src2_imm_p1  <= 1'b0;
    end else if (!stall) begin
      valid_p1     <= ctrl_ok;
      reg_write_p1 <= ctrl_ok && id.id_reg_write;
      mem_read_p1  <= ctrl_ok && id.id_mem_read;
      mem_write_p1 <= ctrl_ok && id.id_mem_write;
      branch_p1    <= ctrl_ok && id.id_branch;
      pc_p1        <= id.id_pc;
      imm_p1       <= id.id_imm;
      rs1_data_p1  <= cap1;
      rs2_data_p1  <= cap2;
      rs1_p1       <= id.id_rs1;
      rs2_p1       <= id.id_rs2;
      rd_p1        <= id.id_rd;
      alu_ctrl_p1  <= id.id_alu_ctrl;
      src1_sel_p1  <= id.id_src1_sel;
      src2_imm_p1  <= id.id_src2_imm;
    end
  end

  // ---- EX operand forwarding (combinational on p1 indices) ----
  fwd_sel u_fwd1 (
    .rs(rs1_p1), .base(rs1_data_p1),
    .a_we(exmem_reg_write), .a_rd(exmem_rd), .a_data(exmem_alu_out),
    .b_we(memwb_reg_write), .b_rd(memwb_rd), .b_data(memwb_wdata),
    .data(fwd1)
  );

  fwd_sel u_fwd2 (
    .rs(rs2_p1), .base(rs2_data_p1),
    .a_we(exmem_reg_write), .a_rd(exmem_rd), .a_data(exmem_alu_out),
    .b_we(memwb_reg_write), .b_rd(memwb_rd), .b_data(memwb_wdata),
    .data(fwd2)
  );

  always_comb begin
    src1 = '0;
    case (src1_sel_p1)
      SRC1_RS1: src1 = fwd1;
      SRC1_PC:  src1 = pc_p1;
      default:  src1 = '0;
    endcase
  end

  assign src2         = src2_imm_p1 ? imm_p1 : fwd2;
  assign store_data   = fwd2;
  assign alu_ctrl     = alu_ctrl_p1;
  assign ex_pc        = pc_p1;
  assign ex_imm       = imm_p1;
  assign ex_rd        = rd_p1;
  assign ex_valid     = valid_p1;
  assign ex_reg_write = reg_write_p1;
  assign ex_mem_read  = mem_read_p1;
  assign ex_mem_write = mem_write_p1;
  assign ex_branch    = branch_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: an instruction-level model of the ID/EX
// slot checked every cycle, plus hand-computed expectations at key points.
module tb_ex_operand_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_alu_out, memwb_wdata;
  logic [31:0] src1, src2, store_data, ex_pc, ex_imm;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, load_use_stall;

  int n_pass  = 0;
  int n_total = 0;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id(bus),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_alu_out(exmem_alu_out),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_wdata(memwb_wdata),
    .src1(src1), .src2(src2), .alu_ctrl(alu_ctrl), .store_data(store_data),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model of the instruction currently sitting in EX.
  logic        m_live = 1'b0, m_known;
  logic        m_valid, m_rw, m_mr, m_mw, m_br, m_simm;
  logic [31:0] m_pc, m_imm, m_v1, m_v2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_alu;
  logic [1:0]  m_sel;

  function automatic logic m_lus();
    return m_valid && m_mr && (m_rd != 0) && bus.id_valid &&
           ((bus.id_use_rs1 && bus.id_rs1 == m_rd) || (bus.id_use_rs2 && bus.id_rs2 == m_rd));
  endfunction

  function automatic logic [31:0] reg_value(input logic [4:0] rs, input logic [31:0] stored);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_alu_out;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_wdata;
    return stored;
  endfunction

  function automatic logic [31:0] wb_value(input logic [4:0] rs, input logic [31:0] rf);
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_wdata;
    return rf;
  endfunction

  always @(posedge clk) begin
    logic lus;
    lus = m_lus();
    if (rst) begin
      m_live = 1'b1; m_known = 1'b1;
      {m_valid, m_rw, m_mr, m_mw, m_br, m_simm} = '0;
      {m_pc, m_imm, m_v1, m_v2} = '0;
      {m_rs1, m_rs2, m_rd, m_alu, m_sel} = '0;
    end else if (m_live && !stall) begin
      if (flush || lus) begin
        {m_valid, m_rw, m_mr, m_mw, m_br} = '0;
        m_known = 1'b0;
      end else begin
        m_known = 1'b1;
        m_valid = bus.id_valid;
        m_rw = bus.id_valid & bus.id_reg_write;
        m_mr = bus.id_valid & bus.id_mem_read;
        m_mw = bus.id_valid & bus.id_mem_write;
        m_br = bus.id_valid & bus.id_branch;
        m_pc = bus.id_pc; m_imm = bus.id_imm; m_rd = bus.id_rd;
        m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2;
        m_v1 = wb_value(bus.id_rs1, bus.id_rs1_data);
        m_v2 = wb_value(bus.id_rs2, bus.id_rs2_data);
        m_alu = bus.id_alu_ctrl; m_sel = bus.id_src1_sel; m_simm = bus.id_src2_imm;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
      chk("ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
          {28'b0, m_rw, m_mr, m_mw, m_br});
      chk("load_use_stall", {31'b0, load_use_stall}, {31'b0, m_lus()});
      if (m_known) begin
        chk("src1", src1, (m_sel == 2'b00) ? reg_value(m_rs1, m_v1) :
                          (m_sel == 2'b01) ? m_pc : 32'h0);
        chk("src2", src2, m_simm ? m_imm : reg_value(m_rs2, m_v2));
        chk("store_data", store_data, reg_value(m_rs2, m_v2));
        chk("alu_ctrl", {28'b0, alu_ctrl}, {28'b0, m_alu});
        chk("ex_pc_imm", ex_pc ^ {ex_imm[15:0], ex_imm[31:16]}, m_pc ^ {m_imm[15:0], m_imm[31:16]});
        chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2,
                        input logic u1, u2, input logic [31:0] d1, d2, imm,
                        input logic [3:0] alu, input logic [1:0] sel, input logic simm,
                        input logic [4:0] rd, input logic rw, mr, mw, br);
    bus.id_valid = v; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_rs1_data = d1; bus.id_rs2_data = d2;
    bus.id_imm = imm; bus.id_alu_ctrl = alu; bus.id_src1_sel = sel; bus.id_src2_imm = simm;
    bus.id_rd = rd; bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    bus.id_branch = br;
  endtask

  task automatic id_idle();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_AND, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fwd_set(input logic [4:0] erd, input logic ewe, input logic [31:0] eout,
                         input logic [4:0] mrd, input logic mwe, input logic [31:0] mwd);
    exmem_rd = erd; exmem_reg_write = ewe; exmem_alu_out = eout;
    memwb_rd = mrd; memwb_reg_write = mwe; memwb_wdata = mwd;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    fwd_set(0, 0, 0, 0, 0, 0);
    id_set(1, 32'h40, 1, 2, 1, 1, 5, 6, 7, ALU_ADD, 2'b00, 0, 8, 1, 1, 0, 0);
    step(); step(); #2;
    chk("rst ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst src1", src1, 32'h0);
    chk("rst alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    chk("rst load_use", {31'b0, load_use_stall}, 32'h0);
    rst = 1'b0;

    // add x5,x1,x2 then sub x6,x5,x1 with add result forwarded from EX/MEM
    id_set(1, 32'h100, 1, 2, 1, 1, 32'h3, 32'h4, 0, ALU_ADD, 2'b00, 0, 5, 1, 0, 0, 0);
    step();
    id_set(1, 32'h104, 5, 1, 1, 1, 32'h0, 32'h3, 0, ALU_SUB, 2'b00, 0, 6, 1, 0, 0, 0);
    step();
    fwd_set(5, 1, 32'h10, 0, 0, 0); id_idle(); #2;
    chk("sub src1 fwd", src1, 32'h10);
    chk("sub alu_ctrl", {28'b0, alu_ctrl}, 32'h6);
    chk("sub src2", src2, 32'h3);

    // EX/MEM beats MEM/WB on the same register
    fwd_set(0, 0, 0, 0, 0, 0);
    id_set(1, 32'h108, 0, 7, 0, 1, 0, 32'h1111_1111, 0, ALU_ADD, 2'b00, 0, 8, 1, 0, 0, 0);
    step();
    fwd_set(7, 1, 32'hAAAA_0000, 7, 1, 32'h5555_0000); id_idle(); #2;
    chk("prio src2", src2, 32'hAAAA_0000);
    chk("prio store_data", store_data, 32'hAAAA_0000);
    fwd_set(0, 0, 0, 7, 1, 32'h5555_0000); #1;
    chk("memwb src2", src2, 32'h5555_0000);

    // x0 never forwarded
    fwd_set(0, 1, 32'hAAAA_0000, 0, 1, 32'h5555_0000);
    id_set(1, 32'h10C, 0, 0, 1, 1, 32'h2222_2222, 32'h1111_1111, 0, ALU_ADD, 2'b00, 0, 8, 1, 0, 0, 0);
    step(); id_idle(); #2;
    chk("x0 src2", src2, 32'h1111_1111);
    chk("x0 src1", src1, 32'h2222_2222);

    // lw x3 then add x4,x3,x3: exactly one bubble, then MEM/WB forward
    fwd_set(0, 0, 0, 0, 0, 0);
    id_set(1, 32'h110, 2, 0, 1, 0, 32'h1000, 0, 32'h8, ALU_ADD, 2'b00, 1, 3, 1, 1, 0, 0);
    step();
    id_set(1, 32'h114, 3, 3, 1, 1, 0, 0, 0, ALU_ADD, 2'b00, 0, 4, 1, 0, 0, 0);
    #2;
    chk("lu asserted", {31'b0, load_use_stall}, 32'h1);
    step(); #2;
    chk("lu bubble valid", {31'b0, ex_valid}, 32'h0);
    chk("lu released", {31'b0, load_use_stall}, 32'h0);
    step();
    fwd_set(0, 0, 0, 3, 1, 32'h1234); id_idle(); #2;
    chk("lu src1", src1, 32'h1234);
    chk("lu src2", src2, 32'h1234);
    chk("lu valid", {31'b0, ex_valid}, 32'h1);

    // flush, then stall holding over a flush, then reset during stall
    fwd_set(0, 0, 0, 0, 0, 0);
    id_set(1, 32'h200, 1, 2, 1, 1, 1, 2, 0, ALU_OR, 2'b00, 0, 9, 1, 0, 0, 0);
    flush = 1'b1;
    step(); flush = 1'b0; #2;
    chk("flush valid", {31'b0, ex_valid}, 32'h0);
    chk("flush reg_write", {31'b0, ex_reg_write}, 32'h0);
    step(); #2;
    chk("load pc", ex_pc, 32'h200);
    stall = 1'b1; flush = 1'b1;
    id_set(1, 32'h300, 1, 2, 1, 1, 1, 2, 0, ALU_XOR, 2'b00, 0, 10, 0, 0, 1, 0);
    step(); #2;
    chk("stall valid", {31'b0, ex_valid}, 32'h1);
    chk("stall reg_write", {31'b0, ex_reg_write}, 32'h1);
    chk("stall pc", ex_pc, 32'h200);
    flush = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; stall = 1'b0; #2;
    chk("rst in stall", {31'b0, ex_valid}, 32'h0);

    // flush coinciding with load-use gives a single bubble
    id_set(1, 32'h120, 2, 0, 1, 0, 32'h1000, 0, 32'h4, ALU_ADD, 2'b00, 1, 3, 1, 1, 0, 0);
    step();
    id_set(1, 32'h124, 3, 0, 1, 0, 0, 0, 0, ALU_ADD, 2'b00, 0, 4, 1, 0, 0, 0);
    flush = 1'b1;
    step(); flush = 1'b0; #2;
    chk("flush+lu bubble", {31'b0, ex_valid}, 32'h0);
    step(); #2;
    chk("flush+lu next pc", ex_pc, 32'h124);

    // stall defers the load-use bubble
    id_set(1, 32'h130, 2, 0, 1, 0, 32'h1000, 0, 32'h4, ALU_ADD, 2'b00, 1, 3, 1, 1, 0, 0);
    step();
    id_set(1, 32'h134, 0, 3, 0, 1, 0, 0, 0, ALU_ADD, 2'b00, 0, 4, 1, 0, 0, 0);
    stall = 1'b1;
    step(); #2;
    chk("stall+lu held", {30'b0, ex_valid, ex_mem_read}, 32'h3);
    chk("stall+lu pending", {31'b0, load_use_stall}, 32'h1);
    stall = 1'b0;
    step(); #2;
    chk("stall+lu bubble", {31'b0, ex_valid}, 32'h0);

    // capture-time WB bypass, then auipc operands
    fwd_set(0, 0, 0, 9, 1, 32'hDEAD_BEEF);
    id_set(1, 32'h400, 9, 0, 1, 0, 32'h0, 0, 0, ALU_ADD, 2'b00, 0, 10, 1, 0, 0, 0);
    step();
    fwd_set(0, 0, 0, 0, 0, 0); id_idle(); #2;
    chk("cap bypass src1", src1, 32'hDEAD_BEEF);
    id_set(1, 32'h100, 0, 0, 0, 0, 0, 0, 32'h2000, ALU_ADD, 2'b01, 1, 11, 1, 0, 0, 0);
    step(); id_idle(); #2;
    chk("auipc src1", src1, 32'h100);
    chk("auipc src2", src2, 32'h2000);

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
